dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache. Sits directly downstream of the pipeline's MEM stage.
- Consumes the datapath's data-side requests (dmemREN, dmemWEN, dmemaddr, dmemstore, datomic, halt) and returns dhit and dmemload.
- Talks to the memory controller/arbiter through a word-wide request/wait handshake.
- Implements the LL/SC link register and the halt-time dirty-block flush.

---
 rtl/dcache_wb_if.sv | 32 +++
 rtl/dcache_wb.sv | 191 +++++++++++++++++++
 tb/tb_dcache_wb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_if.sv
// Data-side bundle: pipeline request/response plus word-wide memory handshake.
interface dcache_wb_if;
  // pipeline side
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  // memory side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  // cache view
  modport slave (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  // environment view (pipeline + memory controller)
  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate L1 D-cache with LL/SC link and halt flush.
module dcache_wb #(
  parameter int unsigned SETS = 16
) (
  input logic        CLK,
  input logic        RST,
  dcache_wb_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 3;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FL0, FL1, DONE
  } state_t;

  state_t            state, state_n;
  logic [SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [31:0]       word0 [SETS];
  logic [31:0]       word1 [SETS];
  logic              link_valid;
  logic [29:0]       link_addr;
  logic [IDX_W-1:0]  cnt, cnt_n;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              req_off;
  logic              hit, link_match, is_sc, sc_fail, last_set;
  logic              store_we, fill0, fill1, flush_clr, link_set, link_clr;
  logic              dhit, flushed, dren, dwen;
  logic [31:0]       dmemload, daddr, dstore;
  logic              unused_addr_bits;

  // Address decode and lookup
  assign req_tag          = bus.dmemaddr[31:IDX_W+3];
  assign req_idx          = bus.dmemaddr[IDX_W+2:3];
  assign req_off          = bus.dmemaddr[2];
  assign unused_addr_bits = ^bus.dmemaddr[1:0];
  assign hit        = valid[req_idx] && (tags[req_idx] == req_tag);
  assign link_match = link_valid && (link_addr == bus.dmemaddr[31:2]);
  assign is_sc      = bus.dmemWEN && bus.datomic;
  assign sc_fail    = is_sc && !link_match;
  assign last_set   = (cnt == IDX_W'(SETS - 1));

  // Next-state, outputs and array write strobes
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dhit      = 1'b0;
    dmemload  = 32'd0;
    flushed   = 1'b0;
    dren      = 1'b0;
    dwen      = 1'b0;
    daddr     = 32'd0;
    dstore    = 32'd0;
    store_we  = 1'b0;
    fill0     = 1'b0;
    fill1     = 1'b0;
    flush_clr = 1'b0;
    link_set  = 1'b0;
    link_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sc_fail) begin
          // failed SC completes at once with no side effects
          dhit = 1'b1;
        end else if (bus.dmemREN || bus.dmemWEN) begin
          if (hit) begin
            dhit = 1'b1;
            if (bus.dmemWEN) begin
              store_we = 1'b1;
              dmemload = {31'd0, is_sc};
              link_clr = link_match;
            end else begin
              dmemload = req_off ? word1[req_idx] : word0[req_idx];
              link_set = bus.datomic;
            end
          end else begin
            state_n = (valid[req_idx] && dirty[req_idx]) ? WB0 : FETCH0;
          end
        end else if (bus.halt) begin
          state_n = FLUSH_CHK;
          cnt_n   = '0;
        end
      end
      WB0: begin
        dwen   = 1'b1;
        daddr  = {tags[req_idx], req_idx, 3'b000};
        dstore = word0[req_idx];
        if (!bus.dwait) state_n = WB1;
      end
      WB1: begin
        dwen   = 1'b1;
        daddr  = {tags[req_idx], req_idx, 3'b100};
        dstore = word1[req_idx];
        if (!bus.dwait) state_n = FETCH0;
      end
      FETCH0: begin
        dren  = 1'b1;
        daddr = {req_tag, req_idx, 3'b000};
        if (!bus.dwait) begin
          fill0   = 1'b1;
          state_n = FETCH1;
        end
      end
      FETCH1: begin
        dren  = 1'b1;
        daddr = {req_tag, req_idx, 3'b100};
        if (!bus.dwait) begin
          fill1   = 1'b1;
          state_n = IDLE;
        end
      end
      FLUSH_CHK: begin
        if (valid[cnt] && dirty[cnt]) state_n = FL0;
        else if (last_set)            state_n = DONE;
        else                          cnt_n   = cnt + 1'b1;
      end
      FL0: begin
        dwen   = 1'b1;
        daddr  = {tags[cnt], cnt, 3'b000};
        dstore = word0[cnt];
        if (!bus.dwait) state_n = FL1;
      end
      FL1: begin
        dwen   = 1'b1;
        daddr  = {tags[cnt], cnt, 3'b100};
        dstore = word1[cnt];
        if (!bus.dwait) begin
          flush_clr = 1'b1;
          if (last_set) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt + 1'b1;
            state_n = FLUSH_CHK;
          end
        end
      end
      DONE: flushed = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // State, counter, tag-status and link registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      valid      <= '0;
      dirty      <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (store_we) dirty[req_idx] <= 1'b1;
      if (fill1) begin
        valid[req_idx] <= 1'b1;
        dirty[req_idx] <= 1'b0;
      end
      if (flush_clr) dirty[cnt] <= 1'b0;
      if (link_set) begin
        link_valid <= 1'b1;
        link_addr  <= bus.dmemaddr[31:2];
      end else if (link_clr) begin
        link_valid <= 1'b0;
      end
    end
  end

  // Data and tag arrays; contents are meaningless until valid is set
  always_ff @(posedge CLK) begin
    if (store_we) begin
      if (req_off) word1[req_idx] <= bus.dmemstore;
      else         word0[req_idx] <= bus.dmemstore;
    end
    if (fill0) word0[req_idx] <= bus.dload;
    if (fill1) begin
      word1[req_idx] <= bus.dload;
      tags[req_idx]  <= req_tag;
    end
  end

  assign bus.dhit     = dhit;
  assign bus.dmemload = dmemload;
  assign bus.flushed  = flushed;
  assign bus.dREN     = dren;
  assign bus.dWEN     = dwen;
  assign bus.daddr    = daddr;
  assign bus.dstore   = dstore;
endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: memory transfers checked against an expected queue.
module tb_dcache_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_wb_if bus ();

  dcache_wb #(.SETS(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] mem [1024];
  int          errors = 0;
  int          checks = 0;
  int          wait_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.we = we; x.addr = a; x.data = d;
    exp_q.push_back(x);
  endtask

  // Memory model: combinational read data, wait pattern chosen per mode
  always_comb bus.dload = mem[bus.daddr[11:2]];

  always @(negedge clk) begin
    case (wait_mode)
      0:       bus.dwait <= ($urandom_range(0, 2) == 0);
      1:       bus.dwait <= 1'b0;
      default: bus.dwait <= bus.dWEN && bus.daddr[2];
    endcase
  end

  // Scoreboard: every completed transfer must match the head of the queue
  always @(posedge clk) begin
    xfer_t x;
    if (!rst) begin
      check("dren_dwen_excl", 32'(bus.dREN & bus.dWEN), 32'd0);
      if ((bus.dREN || bus.dWEN) && bus.dwait === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", bus.daddr, 32'hFFFF_FFFF);
        end else begin
          x = exp_q.pop_front();
          check("xfer_we", 32'(bus.dWEN), 32'(x.we));
          check("xfer_addr", bus.daddr, x.addr);
          if (x.we) check("xfer_data", bus.dstore, x.data);
          if (bus.dWEN) mem[bus.daddr[11:2]] <= bus.dstore;
        end
      end
    end
  end

  // Hold a request until dhit, then check the returned value and hit latency
  task automatic do_req(input string tag, input logic r, input logic w, input logic at,
                        input logic [31:0] a, input logic [31:0] st,
                        input logic [31:0] exp_ld, input logic exp_hit0);
    int n;
    n = 0;
    bus.dmemREN = r; bus.dmemWEN = w; bus.datomic = at;
    bus.dmemaddr = a; bus.dmemstore = st;
    #1;
    while (bus.dhit !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(bus.dhit), 32'd1);
    check({tag, "_load"}, bus.dmemload, exp_ld);
    check({tag, "_hit0"}, 32'(n == 0), 32'(exp_hit0));
    @(posedge clk); #1;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.datomic = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = init_val(32'(i * 4));
    mem[32'h100 >> 2] = 32'h0000_AAAA;
    mem[32'h104 >> 2] = 32'h0000_BBBB;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.datomic = 1'b0;
    bus.dmemaddr = 32'd0; bus.dmemstore = 32'd0; bus.halt = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_dhit", 32'(bus.dhit), 32'd0);
    check("rst_dren", 32'(bus.dREN), 32'd0);
    check("rst_dwen", 32'(bus.dWEN), 32'd0);
    check("rst_daddr", bus.daddr, 32'd0);
    check("rst_dstore", bus.dstore, 32'd0);
    check("rst_dmemload", bus.dmemload, 32'd0);
    check("rst_flushed", 32'(bus.flushed), 32'd0);
    @(posedge clk); #1;

    // cold miss then same-block hit
    push(1'b0, 32'h100, 32'd0); push(1'b0, 32'h104, 32'd0);
    do_req("lw100", 1, 0, 0, 32'h100, 0, 32'h0000_AAAA, 1'b0);
    do_req("lw104", 1, 0, 0, 32'h104, 0, 32'h0000_BBBB, 1'b1);

    // dirty conflict eviction
    do_req("sw100", 0, 1, 0, 32'h100, 32'h1234, 32'd0, 1'b1);
    push(1'b1, 32'h100, 32'h1234); push(1'b1, 32'h104, 32'h0000_BBBB);
    push(1'b0, 32'h180, 32'd0);    push(1'b0, 32'h184, 32'd0);
    do_req("lw180", 1, 0, 0, 32'h180, 0, init_val(32'h180), 1'b0);
    check("q_evict", 32'(exp_q.size()), 32'd0);

    // LL/SC success then failure
    push(1'b0, 32'h200, 32'd0); push(1'b0, 32'h204, 32'd0);
    do_req("ll200", 1, 0, 1, 32'h200, 0, init_val(32'h200), 1'b0);
    do_req("sc200_ok", 0, 1, 1, 32'h200, 32'd5, 32'd1, 1'b1);
    do_req("sc200_fail", 0, 1, 1, 32'h200, 32'd6, 32'd0, 1'b1);
    do_req("lw200_a", 1, 0, 0, 32'h200, 0, 32'd5, 1'b1);

    // plain store breaks the link
    do_req("ll200_b", 1, 0, 1, 32'h200, 0, 32'd5, 1'b1);
    do_req("sw200", 0, 1, 0, 32'h200, 32'd7, 32'd0, 1'b1);
    do_req("sc200_broken", 0, 1, 1, 32'h200, 32'd9, 32'd0, 1'b1);
    do_req("lw200_b", 1, 0, 0, 32'h200, 0, 32'd7, 1'b1);
    check("q_llsc", 32'(exp_q.size()), 32'd0);

    // halt flush with dirty sets 1 and 5, clean set 2
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push(1'b0, 32'h008, 32'd0); push(1'b0, 32'h00C, 32'd0);
    do_req("sw008", 0, 1, 0, 32'h008, 32'h11, 32'd0, 1'b0);
    push(1'b0, 32'h028, 32'd0); push(1'b0, 32'h02C, 32'd0);
    do_req("sw028", 0, 1, 0, 32'h028, 32'h55, 32'd0, 1'b0);
    push(1'b0, 32'h010, 32'd0); push(1'b0, 32'h014, 32'd0);
    do_req("lw010", 1, 0, 0, 32'h010, 0, init_val(32'h010), 1'b0);
    push(1'b1, 32'h008, 32'h11); push(1'b1, 32'h00C, init_val(32'h00C));
    push(1'b1, 32'h028, 32'h55); push(1'b1, 32'h02C, init_val(32'h02C));
    bus.halt = 1'b1;
    n = 0;
    while (bus.flushed !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("flushed", 32'(bus.flushed), 32'd1);
    check("q_flush", 32'(exp_q.size()), 32'd0);
    bus.halt = 1'b0;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h008;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("done_dhit", 32'(bus.dhit), 32'd0);
      check("done_flushed", 32'(bus.flushed), 32'd1);
    end
    bus.dmemREN = 1'b0;

    // reset while stalled in the second write-back beat
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("post_rst_flushed", 32'(bus.flushed), 32'd0);
    push(1'b0, 32'h100, 32'd0); push(1'b0, 32'h104, 32'd0);
    do_req("lw100_c", 1, 0, 0, 32'h100, 0, 32'h1234, 1'b0);
    do_req("sw100_c", 0, 1, 0, 32'h100, 32'h99, 32'd0, 1'b1);
    wait_mode = 2;
    push(1'b1, 32'h100, 32'h99);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h180;
    #1;
    n = 0;
    while (!(bus.dWEN === 1'b1 && bus.daddr === 32'h104) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wb1_addr", bus.daddr, 32'h104);
    @(negedge clk); #1;
    rst = 1'b1;
    bus.dmemREN = 1'b0;
    @(posedge clk); #1;
    check("rst_wb1_dwen", 32'(bus.dWEN), 32'd0);
    check("rst_wb1_dren", 32'(bus.dREN), 32'd0);
    check("rst_wb1_flushed", 32'(bus.flushed), 32'd0);
    rst = 1'b0;
    wait_mode = 0;
    check("q_rst", 32'(exp_q.size()), 32'd0);
    push(1'b0, 32'h100, 32'd0); push(1'b0, 32'h104, 32'd0);
    do_req("lw100_d", 1, 0, 0, 32'h100, 0, 32'h99, 1'b0);
    check("q_end", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
